// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - program_sequencer state encoding and default geometry
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  localparam int SEQ_AW      = 3;
  localparam int SEQ_IW      = 8;
  localparam int SEQ_ROM_LAT = 1;

  function automatic int timer_width(int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/seq_fetch_timer.sv
// rtl/seq_fetch_timer.sv - loadable down-counter, done ROM_LAT cycles after load
module seq_fetch_timer
  import seq_pkg::*;
#(
  parameter int ROM_LAT = SEQ_ROM_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int CW = timer_width(ROM_LAT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading LAT-1 makes done visible on the cycle the ROM data is valid.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(ROM_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/issue controller owning the PC
// Optional SEQ_BREAKPOINT_EN adds bp_en/bp_addr/bp_hit.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int AW      = SEQ_AW,
  parameter int IW      = SEQ_IW,
  parameter int ROM_LAT = SEQ_ROM_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  input  logic          restart,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          exec_ready,
  input  logic          jump_req,
  input  logic [AW-1:0] jump_target,
  input  logic          halt_req,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          wrapped
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic          bp_hit
`endif
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [IW-1:0] instr_q;
  logic          wrapped_q, wrap_set;
  logic          fetch_enter, fetch_done;
`ifdef SEQ_BREAKPOINT_EN
  logic          bp_hit_q, bp_set;
`endif

  assign pc_inc = pc_q + AW'(1);

  seq_fetch_timer #(.ROM_LAT(ROM_LAT)) u_fetch_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (fetch_enter),
    .done  (fetch_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wrap_set    = 1'b0;
    fetch_enter = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_set      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d     = ST_FETCH;
          fetch_enter = 1'b1;
        end
      end
      ST_FETCH: begin
        if (fetch_done) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (exec_ready) begin
          // halt wins over jump; a halted PC still advances past the instruction
          if (halt_req) begin
            state_d  = ST_HALT;
            pc_d     = pc_inc;
            wrap_set = (pc_q == '1);
          end else begin
            pc_d        = jump_req ? jump_target : pc_inc;
            wrap_set    = !jump_req && (pc_q == '1);
            state_d     = run ? ST_FETCH : ST_IDLE;
            fetch_enter = run;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
`ifdef SEQ_BREAKPOINT_EN
    if (fetch_enter && bp_en && (pc_d == bp_addr)) begin
      state_d     = ST_HALT;
      fetch_enter = 1'b0;
      bp_set      = 1'b1;
    end
`endif
    if (restart) begin
      state_d     = ST_IDLE;
      pc_d        = '0;
      wrap_set    = 1'b0;
      fetch_enter = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      if ((state_q == ST_FETCH) && fetch_done) instr_q <= rom_data;
      wrapped_q <= !restart && (wrapped_q || wrap_set);
    end
  end

`ifdef SEQ_BREAKPOINT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= !restart && (bp_hit_q || bp_set);
    end
  end

  assign bp_hit = bp_hit_q;
`endif

  always_comb begin
    instr_valid = (state_q == ST_ISSUE);
    halted      = (state_q == ST_HALT);
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;
  import seq_pkg::*;

  localparam int AW    = SEQ_AW;
  localparam int IW    = SEQ_IW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, run, step, restart, exec_ready, jump_req, halt_req;
  logic [AW-1:0] jump_target, rom_addr, pc;
  logic [IW-1:0] rom_data, instr;
  logic          instr_valid, halted, wrapped;
`ifdef SEQ_BREAKPOINT_EN
  logic          bp_en, bp_hit;
  logic [AW-1:0] bp_addr;
`endif

  logic [IW-1:0] rom [DEPTH];
  int tests = 0;
  int fails = 0;
  int m_pc  = 0;
  bit m_wrapped = 1'b0;
  bit m_halted  = 1'b0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  program_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .restart     (restart),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_ready  (exec_ready),
    .jump_req    (jump_req),
    .jump_target (jump_target),
    .halt_req    (halt_req),
    .pc          (pc),
    .halted      (halted),
    .wrapped     (wrapped)
`ifdef SEQ_BREAKPOINT_EN
    ,
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .bp_hit      (bp_hit)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 0;
    m_wrapped = 1'b0;
    m_halted  = 1'b0;
  endtask

  // Wait for the next issued instruction, optionally stall, then accept it.
  task automatic issue_one(input bit jmp, input int tgt, input bit hlt, input int stall, input int exp_gap);
    int gap;
    gap = 0;
    while (!instr_valid && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("valid_seen", instr_valid, 1);
    if (exp_gap >= 0) check("gap", gap, exp_gap);
    check("instr", instr, rom[m_pc]);
    check("pc", pc, m_pc);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, rom[m_pc]);
    end
    exec_ready  = 1'b1;
    jump_req    = jmp;
    jump_target = AW'(tgt);
    halt_req    = hlt;
    @(negedge clk);
    exec_ready = 1'b0;
    jump_req   = 1'b0;
    halt_req   = 1'b0;
    if (hlt || !jmp) begin
      if (m_pc == DEPTH - 1) m_wrapped = 1'b1;
      m_pc = (m_pc + 1) % DEPTH;
    end else begin
      m_pc = tgt;
    end
    m_halted = hlt;
`ifdef SEQ_BREAKPOINT_EN
    if (!hlt && run && bp_en && (m_pc == int'(bp_addr))) m_halted = 1'b1;
`endif
    check("valid_drop", instr_valid, 0);
    check("pc_next", pc, m_pc);
    check("wrapped", wrapped, m_wrapped);
    check("halted", halted, m_halted);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_valid", instr_valid, 0);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_valid", instr_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; restart = 1'b0;
    exec_ready = 1'b0; jump_req = 1'b0; halt_req = 1'b0; jump_target = '0;
`ifdef SEQ_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'(8'hA0 + i);

    repeat (2) @(negedge clk);
    check("reset_pc", pc, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_instr", instr, 0);
    check("reset_valid", instr_valid, 0);
    check("reset_halted", halted, 0);
    check("reset_wrapped", wrapped, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // free run through the whole program and across the wrap
    run = 1'b1;
    issue_one(0, 0, 0, 0, 2);
    for (int i = 1; i < DEPTH; i++) issue_one(0, 0, 0, 0, 1);
    check("wrap_set", wrapped, 1);

    // backpressure, jump, then halt beating jump
    issue_one(0, 0, 0, 0, 1);
    issue_one(0, 0, 0, 0, 1);
    issue_one(0, 0, 0, 5, 1);
    issue_one(1, 6, 0, 0, 1);
    issue_one(1, 4, 0, 0, 1);
    issue_one(1, 6, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_hold", halted, 1);
      check("halt_valid", instr_valid, 0);
      check("halt_pc", pc, 5);
    end
    run = 1'b0;
    do_restart();
    idle(2);

    // single step; a step still high during FETCH must not issue a second one
    step = 1'b1; @(negedge clk); step = 1'b0;
    issue_one(0, 0, 0, 0, 1);
    idle(10);
    step = 1'b1; @(negedge clk); @(negedge clk); step = 1'b0;
    issue_one(0, 0, 0, 0, 0);
    idle(10);
    check("step_pc", pc, 2);
    step = 1'b1; @(negedge clk); step = 1'b0;
    issue_one(0, 0, 0, 0, 1);
    idle(3);

    // asynchronous reset while an instruction is offered
    run = 1'b1;
    @(negedge clk); @(negedge clk);
    check("pre_reset_valid", instr_valid, 1);
    check("pre_reset_instr", instr, rom[m_pc]);
    rst_n = 1'b0;
    #1;
    check("async_valid", instr_valid, 0);
    check("async_pc", pc, 0);
    check("async_rom_addr", rom_addr, 0);
    check("async_instr", instr, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    issue_one(0, 0, 0, 0, 2);
    run = 1'b0;
    issue_one(0, 0, 0, 0, 1);
    idle(4);

    // random program, random stalls and jumps
    do_restart();
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
    run = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue_one($urandom_range(3) == 0, $urandom_range(DEPTH - 1), 0, $urandom_range(3), -1);
    end
    run = 1'b0;
    issue_one(0, 0, 0, 0, -1);
    idle(4);

`ifdef SEQ_BREAKPOINT_EN
    for (int i = 0; i < DEPTH; i++) rom[i] = IW'(8'hA0 + i);
    do_restart();
    bp_en = 1'b1; bp_addr = AW'(5);
    run = 1'b1;
    for (int i = 0; i < 5; i++) issue_one(0, 0, 0, 0, -1);
    check("bp_hit", bp_hit, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", instr_valid, 0);
      check("bp_halted", halted, 1);
      check("bp_pc", pc, 5);
    end
    run = 1'b0;
    do_restart();
    check("bp_clear", bp_hit, 0);
    bp_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
